booth_seq_divider8: RTL and testbench

- Iterative signed divider, the inverse of the 8x8 Booth multiplier: 16-bit dividend / 8-bit divisor gives an 8-bit quotient and an 8-bit remainder.
- Radix-2 restoring core on magnitudes, one quotient bit per clock, with sign fix-up at the end.
- Sits beside the multiplier in the arithmetic datapath.
- Uses a start/busy/done handshake; results are held until the next operation completes.

---
 rtl/booth_seq_divider8.sv | 127 ++++++++++++
 tb/tb_booth_seq_divider8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_divider8.sv
// booth_seq_divider8: iterative signed 16/8 divider (restoring radix-2 on magnitudes, sign fix-up at the end)
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, sampled only in IDLE
//   DD        16-bit two's complement dividend
//   DR        8-bit two's complement divisor
//   tc        (only with BOOTH_DIV_UNSIGNED_EN) 1 = signed, 0 = unsigned operands
//   Quotient  registered 8-bit quotient
//   Remainder registered 8-bit remainder, sign of the dividend
//   busy      high from the accepting edge through the FIX edge
//   done      one-cycle result-valid pulse
//   dbz       divide-by-zero flag, held until the next result
//   ovf       quotient-overflow flag, held until the next result
// Optional macro: BOOTH_DIV_UNSIGNED_EN adds the tc port.
module booth_seq_divider8 #(
  parameter int ITER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] DD,
  input  logic [7:0]  DR,
`ifdef BOOTH_DIV_UNSIGNED_EN
  input  logic        tc,
`endif
  output logic [7:0]  Quotient,
  output logic [7:0]  Remainder,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic        ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_sd, r_sr, r_tc, r_dbz_i, r_pre_ovf;
  logic [8:0]  r_dr;
  logic [8:0]  r_rem;
  logic [7:0]  r_q;
  logic [7:0]  r_quo, r_rmd;
  logic        r_busy, r_done, r_dbz, r_ovf;
  logic        w_tc, w_sd, w_sr, w_neg, w_ovf;
  logic [16:0] w_dd_mag;
  logic [8:0]  w_dr_mag;
  logic [9:0]  w_shift;
  logic [10:0] w_diff;
  logic [7:0]  w_qs, w_rs;
`ifdef BOOTH_DIV_UNSIGNED_EN
  assign w_tc = tc;
`else
  assign w_tc = 1'b1;
`endif
  assign w_sd     = DD[15] & w_tc;
  assign w_sr     = DR[7] & w_tc;
  // Negating -32768 / -128 in their own width yields 0x8000 / 0x80, which zero-extend to the true magnitude.
  assign w_dd_mag = {1'b0, w_sd ? -DD : DD};
  assign w_dr_mag = {1'b0, w_sr ? -DR : DR};
  // Extra headroom keeps the borrow correct even on overflowing operands whose result is discarded.
  assign w_shift  = {r_rem, r_q[7]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_dr};
  assign w_neg    = r_sd ^ r_sr;
  assign w_qs     = w_neg ? -r_q : r_q;
  assign w_rs     = r_sd ? -r_rem[7:0] : r_rem[7:0];
  // A negative quotient may reach 128, a positive one only 127; unsigned keeps the full 8-bit range.
  assign w_ovf    = r_pre_ovf | (r_tc & ((~w_neg & r_q[7]) | (w_neg & (r_q > 8'd128))));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sd      <= 1'b0;
      r_sr      <= 1'b0;
      r_tc      <= 1'b0;
      r_dbz_i   <= 1'b0;
      r_pre_ovf <= 1'b0;
      r_dr      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_quo     <= '0;
      r_rmd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_sd      <= w_sd;
          r_sr      <= w_sr;
          r_tc      <= w_tc;
          r_dbz_i   <= (DR == 8'd0);
          r_pre_ovf <= (w_dd_mag[16:8] >= w_dr_mag);
          r_dr      <= w_dr_mag;
          r_rem     <= w_dd_mag[16:8];
          r_q       <= w_dd_mag[7:0];
          r_cnt     <= '0;
          r_busy    <= 1'b1;
          r_state   <= CALC;
        end
        CALC: begin
          r_rem   <= w_diff[10] ? w_shift[8:0] : w_diff[8:0];
          r_q     <= {r_q[6:0], ~w_diff[10]};
          r_cnt   <= r_cnt + 3'd1;
          r_state <= (r_cnt == 3'(ITER - 1)) ? FIX : CALC;
        end
        FIX: begin
          r_dbz   <= r_dbz_i;
          r_ovf   <= ~r_dbz_i & w_ovf;
          r_quo   <= (r_dbz_i | w_ovf) ? 8'd0 : w_qs;
          r_rmd   <= (r_dbz_i | w_ovf) ? 8'd0 : w_rs;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign Quotient  = r_quo;
  assign Remainder = r_rmd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_booth_seq_divider8.sv
// tb_booth_seq_divider8: directed self-checking bench for booth_seq_divider8
module tb_booth_seq_divider8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dd = '0;
  logic [7:0]  dr = '0;
`ifdef BOOTH_DIV_UNSIGNED_EN
  logic        tc = 1'b1;
`endif
  logic [7:0]  quo, rmd;
  logic        busy, done, dbz, ovf;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk = ~clk;
  booth_seq_divider8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .DD(dd), .DR(dr),
`ifdef BOOTH_DIV_UNSIGNED_EN
    .tc(tc),
`endif
    .Quotient(quo), .Remainder(rmd), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dd = a; dr = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int base, output int edge_no);
    bit found = 1'b0;
    edge_no = base;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 edge_no++;
      found = done;
    end
    if (!found) edge_no = -1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({quo, rmd, busy, done, dbz, ovf} !== 20'd0) $display("FAIL reset_outputs got q=%h r=%h b=%b d=%b z=%b o=%b want all 0", quo, rmd, busy, done, dbz, ovf);
    else n_pass++;
    rst_n = 1'b1;
  endtask
  task automatic test_vectors(input string name, input logic [15:0] a [], input logic [7:0] b [], input logic [17:0] exp []);
    int e;
    for (int k = 0; k < a.size(); k++) begin
      launch(a[k], b[k]);
      wait_done(1, e);
      n_total++;
      if (e !== 10) $display("FAIL %s_latency[%0d] got edge %0d want 10", name, k, e);
      else n_pass++;
      n_total++;
      if ({dbz, ovf, quo, rmd} !== exp[k]) $display("FAIL %s_result[%0d] got dbz=%b ovf=%b q=%h r=%h want %h", name, k, dbz, ovf, quo, rmd, exp[k]);
      else n_pass++;
    end
  endtask
  task automatic test_signed;
    test_vectors("signed",
      '{16'd100, 16'hFF9C, 16'hFC00, 16'd100, 16'hFF9C, 16'd127, 16'hFF80},
      '{8'd7,    8'd7,     8'd8,     8'hF9,   8'hF9,    8'd1,    8'd1},
      '{{2'b00, 8'h0E, 8'h02}, {2'b00, 8'hF2, 8'hFE}, {2'b00, 8'h80, 8'h00}, {2'b00, 8'hF2, 8'h02},
        {2'b00, 8'h0E, 8'hFE}, {2'b00, 8'h7F, 8'h00}, {2'b00, 8'h80, 8'h00}});
  endtask
  task automatic test_overflow;
    test_vectors("ovf",
      '{16'd1000, 16'h8000, 16'd128},
      '{8'd7,     8'hFF,    8'd1},
      '{{2'b01, 16'h0000}, {2'b01, 16'h0000}, {2'b01, 16'h0000}});
  endtask
  task automatic test_dbz;
    test_vectors("dbz", '{16'h1234}, '{8'd0}, '{{2'b10, 16'h0000}});
  endtask
  task automatic test_hold;
    launch(16'd100, 8'd7);
    wait_done(1, n_total);
    n_total = n_total - 10 + 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({done, busy, quo, rmd} !== {2'b00, 8'h0E, 8'h02}) $display("FAIL hold got done=%b busy=%b q=%h r=%h want 0 0 0e 02", done, busy, quo, rmd);
    else n_pass++;
  endtask
  task automatic test_ignore_start;
    int e;
    launch(16'd100, 8'd7);
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_after_accept got %b want 1", busy);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dd = 16'd5; dr = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4, e);
    n_total++;
    if (e !== 10) $display("FAIL ignore_latency got edge %0d want 10", e);
    else n_pass++;
    n_total++;
    if ({dbz, ovf, quo, rmd} !== {2'b00, 8'h0E, 8'h02}) $display("FAIL ignore_result got dbz=%b ovf=%b q=%h r=%h want 0 0 0e 02", dbz, ovf, quo, rmd);
    else n_pass++;
  endtask
  task automatic test_back_to_back;
    int e;
    @(negedge clk);
    dd = 16'd1000; dr = 8'd100; start = 1'b1;
    @(posedge clk);
    wait_done(1, e);
    n_total++;
    if (e !== 10 || quo !== 8'd10 || rmd !== 8'd0) $display("FAIL b2b_first got edge %0d q=%h r=%h want 10 0a 00", e, quo, rmd);
    else n_pass++;
    dd = 16'hFF9C; dr = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    else n_pass++;
    wait_done(11, e);
    n_total++;
    if (e !== 20) $display("FAIL b2b_latency got edge %0d want 20", e);
    else n_pass++;
    n_total++;
    if ({quo, rmd} !== 16'hF2FE) $display("FAIL b2b_second got q=%h r=%h want f2 fe", quo, rmd);
    else n_pass++;
  endtask
  task automatic test_mid_reset;
    int seen = 0;
    launch(16'hFF9C, 8'd7);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({quo, rmd, busy, done, dbz, ovf} !== 20'd0) $display("FAIL midreset_outputs got q=%h r=%h b=%b d=%b z=%b o=%b want all 0", quo, rmd, busy, done, dbz, ovf);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL midreset_no_done got %0d done pulses want 0", seen);
    else n_pass++;
  endtask
`ifdef BOOTH_DIV_UNSIGNED_EN
  task automatic test_unsigned;
    tc = 1'b0;
    test_vectors("unsigned", '{16'hFE01}, '{8'hFF}, '{{2'b00, 8'hFF, 8'h00}});
    tc = 1'b1;
    test_vectors("tc_signed", '{16'hFE01}, '{8'hFF}, '{{2'b01, 16'h0000}});
  endtask
`endif
  initial begin
    test_reset;
    test_signed;
    test_overflow;
    test_dbz;
    test_ignore_start;
    test_back_to_back;
    test_mid_reset;
`ifdef BOOTH_DIV_UNSIGNED_EN
    test_unsigned;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
